datapath_xyz: RTL and testbench

Register-and-ALU datapath that sits directly downstream of the control unit: it consumes the per-register transfer codes `Tx`, `Ty`, `Tz` and the ALU select `Tula` every clock and updates registers X (operand), Y (accumulator) and Z (display). Z is converted to packed BCD by a sequential double-dabble engine for the seven-segment display stage. All register updates are synchronous, except the asynchronous reset.

---
 rtl/datapath_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 92 +++++++++
 rtl/datapath_xyz.sv | 153 +++++++++++++++
 tb/tb_datapath_xyz.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg
// Shared definitions for the X/Y/Z register datapath and its control unit:
//   - transfer codes applied to every register (HOLD, LOAD, SHR, CLR)
//   - ALU operation select values (ULA_ADD, ULA_SUB)
//   - instruction opcodes used by the control unit
//   - state encoding of the sequential binary-to-BCD engine
//   - the double-dabble digit adjust helper
package datapath_pkg;

  // Per-register transfer codes, identical for X, Y and Z.
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] SHR  = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  // ALU select.
  localparam logic ULA_ADD = 1'b0;
  localparam logic ULA_SUB = 1'b1;

  // Instruction opcodes issued by the control unit.
  //   clrld : X load, Y/Z clear
  //   addld : X load, Y add
  //   add   : Y add
  //   div2  : Y shift right
  //   disp  : Z load, X/Y clear
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLRLD = 3'd1,
    OP_ADDLD = 3'd2,
    OP_ADD   = 3'd3,
    OP_DIV2  = 3'd4,
    OP_DISP  = 3'd5
  } opcode_e;

  // Binary-to-BCD engine states.
  typedef enum logic {
    BCD_IDLE  = 1'b0,
    BCD_SHIFT = 1'b1
  } bcd_state_e;

  // Double-dabble correction: a digit of 5 or more would exceed 9 after the
  // following doubling, so pre-add 3 to carry it into the next digit.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// WIDTH iterations per conversion.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start_i  in   capture bin_i and begin a conversion (aborts a running one)
//   bin_i    in   WIDTH-bit binary value to convert
//   bcd_o    out  4*DIGITS packed BCD of last completed conversion, digit 0 in [3:0]
//   valid_o  out  bcd_o corresponds to the most recently captured value
//   state_o  out  current FSM state (BCD_SHIFT while a conversion runs)
//
// Handshake: start_i is a single-cycle request sampled on every rising edge;
// there is no back-pressure, a new start always wins. valid_o is a level that
// drops on the start edge and rises on the edge that writes the new bcd_o; it
// then stays high until the next start or reset. bcd_o is never updated with a
// partial or aborted result.
module bin2bcd_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  valid_o,
  output bcd_state_e            state_o
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;          // {bcd digits, remaining binary bits}
  localparam int CW = $clog2(WIDTH + 1);

  bcd_state_e     state_q;
  logic [SW-1:0]  sh_q;
  logic [CW-1:0]  cnt_q;
  logic [BW-1:0]  bcd_q;
  logic           valid_q;

  logic [SW-1:0]  adj;
  logic [SW-1:0]  shifted;

  // One double-dabble iteration: correct every digit, then shift the whole
  // {digits, binary} register left by one.
  always_comb begin
    adj = sh_q;
    for (int i = 0; i < DIGITS; i++) begin
      adj[WIDTH + 4*i +: 4] = dd_adjust(sh_q[WIDTH + 4*i +: 4]);
    end
    shifted = adj << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BCD_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      // Start or restart: the previous bcd_q stays visible but is flagged stale.
      state_q <= BCD_SHIFT;
      sh_q    <= {{BW{1'b0}}, bin_i};
      cnt_q   <= CW'(WIDTH);
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BCD_SHIFT: begin
          sh_q  <= shifted;
          cnt_q <= cnt_q - CW'(1);
          // Last iteration: publish the digits produced by this very shift.
          if (cnt_q == CW'(1)) begin
            bcd_q   <= shifted[SW-1 -: BW];
            valid_q <= 1'b1;
            state_q <= BCD_IDLE;
          end
        end
        default: begin
          state_q <= BCD_IDLE;
        end
      endcase
    end
  end

  assign bcd_o   = bcd_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

endmodule

// File: rtl/datapath_xyz.sv
// datapath_xyz
// Register-and-ALU datapath driven by per-register transfer codes from the
// control unit. X holds the operand, Y the accumulator, Z the display value;
// Z is converted to BCD by a sequential double-dabble engine.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   data_in   [WIDTH]       operand loaded into X
//   Tx, Ty, Tz [2]          transfer codes: 00 hold, 01 load, 10 shr, 11 clear
//   Tula                    ALU op: 0 = Y + X, 1 = Y - X
//   x_out, y_out, z_out     register contents
//   cout                    carry of last ALU load into Y (subtract: 1 = no borrow)
//   ovf                     sticky unsigned overflow/borrow, cleared by Ty = 11
//   zero                    registered Y == 0
//   bcd_out [4*DIGITS]      BCD of last completed Z conversion
//   bcd_valid               bcd_out matches current Z
//   bcd_busy                conversion in progress
// DIGITS must satisfy 10^DIGITS > 2^WIDTH - 1.
module datapath_xyz
  import datapath_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    data_in,
  input  logic [1:0]          Tx,
  input  logic [1:0]          Ty,
  input  logic [1:0]          Tz,
  input  logic                Tula,
  output logic [WIDTH-1:0]    x_out,
  output logic [WIDTH-1:0]    y_out,
  output logic [WIDTH-1:0]    z_out,
  output logic                cout,
  output logic                ovf,
  output logic                zero,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  output logic                bcd_busy
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q;

  // ALU works on WIDTH+1 bits; the extra bit is the add carry-out or, for
  // subtraction, the borrow (set when Y < X).
  logic [WIDTH:0]   alu_ext;
  logic             alu_cb;
  logic             alu_cout;

  always_comb begin
    if (Tula == ULA_SUB) begin
      alu_ext = {1'b0, y_q} - {1'b0, x_q};
    end else begin
      alu_ext = {1'b0, y_q} + {1'b0, x_q};
    end
    alu_cb   = alu_ext[WIDTH];
    // Subtract reports carry as "no borrow".
    alu_cout = (Tula == ULA_SUB) ? ~alu_cb : alu_cb;
  end

  // Next-state selection; every source reads pre-edge register values.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;

    case (Tx)
      LOAD:    x_d = data_in;
      SHR:     x_d = x_q >> 1;
      CLR:     x_d = '0;
      default: x_d = x_q;
    endcase

    case (Ty)
      LOAD: begin
        y_d    = alu_ext[WIDTH-1:0];
        cout_d = alu_cout;
        ovf_d  = ovf_q | alu_cb;
      end
      SHR: begin
        y_d    = y_q >> 1;
        cout_d = 1'b0;
      end
      CLR: begin
        y_d    = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end
      default: begin
        y_d = y_q;
      end
    endcase

    case (Tz)
      LOAD:    z_d = y_q;
      SHR:     z_d = z_q >> 1;
      CLR:     z_d = '0;
      default: z_d = z_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= (y_d == '0);
    end
  end

  // Any Z transfer other than hold changes (or may change) Z, so the engine
  // restarts on the value Z takes at this same edge.
  bcd_state_e bcd_state;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (Tz != HOLD),
    .bin_i   (z_d),
    .bcd_o   (bcd_out),
    .valid_o (bcd_valid),
    .state_o (bcd_state)
  );

  assign bcd_busy = (bcd_state == BCD_SHIFT);

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_datapath_xyz.sv
// tb_datapath_xyz
// Directed bench for datapath_xyz. The driver issues transfer codes with
// hand-computed expected register states pushed to exp_q; expected BCD results
// and busy-run lengths go to their own queues. A monitor after every rising
// edge pops and compares whenever the DUT presents a result.
module tb_datapath_xyz;
  import datapath_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;
  localparam int EW     = 3 * WIDTH + 3;   // {x, y, z, cout, ovf, zero}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0]  data_in = '0;
  logic [1:0]        Tx = HOLD, Ty = HOLD, Tz = HOLD;
  logic              Tula = ULA_ADD;
  logic [WIDTH-1:0]  x_out, y_out, z_out;
  logic              cout, ovf, zero;
  logic [BW-1:0]     bcd_out;
  logic              bcd_valid, bcd_busy;

  datapath_xyz #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .Tx        (Tx),
    .Ty        (Ty),
    .Tz        (Tz),
    .Tula      (Tula),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_busy  (bcd_busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] exp_bcd_q[$];
  int            exp_busy_q[$];
  logic          cmd_valid = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor ----------------
  logic [EW-1:0] e;
  logic [BW-1:0] eb;
  int            busy_run = 0;
  logic          busy_prev = 1'b0;
  logic          valid_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_run   = 0;
      busy_prev  = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          check("reg_no_expectation", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          check("x_out", 32'(x_out), 32'(e[26:19]));
          check("y_out", 32'(y_out), 32'(e[18:11]));
          check("z_out", 32'(z_out), 32'(e[10:3]));
          check("cout",  32'(cout),  32'(e[2]));
          check("ovf",   32'(ovf),   32'(e[1]));
          check("zero",  32'(zero),  32'(e[0]));
        end
      end
      if (bcd_valid && !valid_prev) begin
        if (exp_bcd_q.size() == 0) begin
          check("bcd_unexpected_valid", 32'(exp_bcd_q.size()), 32'(1));
        end else begin
          eb = exp_bcd_q.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(eb));
        end
      end
      if (bcd_busy) begin
        busy_run++;
      end else if (busy_prev) begin
        if (exp_busy_q.size() == 0) begin
          check("busy_unexpected", 32'(exp_busy_q.size()), 32'(1));
        end else begin
          check("busy_cycles", 32'(busy_run), 32'(exp_busy_q.pop_front()));
        end
        busy_run = 0;
      end
      busy_prev  = bcd_busy;
      valid_prev = bcd_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] tx, input logic [1:0] ty, input logic [1:0] tz,
                      input logic tula, input logic [7:0] din,
                      input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ez,
                      input logic ec, input logic eo, input logic ezr);
    @(negedge clk);
    Tx = tx; Ty = ty; Tz = tz; Tula = tula; data_in = din;
    cmd_valid = 1'b1;
    exp_q.push_back({ex, ey, ez, ec, eo, ezr});
  endtask

  task automatic idle();
    @(negedge clk);
    Tx = HOLD; Ty = HOLD; Tz = HOLD; Tula = ULA_ADD; data_in = '0;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bcd();
    for (int k = 0; k < 40; k++) begin
      idle();
      if (bcd_valid && !bcd_busy) break;
    end
    check("bcd_wait_timeout", 32'(bcd_valid), 32'(1));
    idle();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_x"},     32'(x_out),     32'(0));
    check({tag, "_y"},     32'(y_out),     32'(0));
    check({tag, "_z"},     32'(z_out),     32'(0));
    check({tag, "_cout"},  32'(cout),      32'(0));
    check({tag, "_ovf"},   32'(ovf),       32'(0));
    check({tag, "_zero"},  32'(zero),      32'(1));
    check({tag, "_bcd"},   32'(bcd_out),   32'(0));
    check({tag, "_valid"}, 32'(bcd_valid), 32'(0));
    check({tag, "_busy"},  32'(bcd_busy),  32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-operation: X = 0x12 and a conversion of Z = 0 running.
    step(LOAD, HOLD, LOAD, ULA_ADD, 8'h12, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
    @(posedge clk);
    #3;
    check("pre_rst_busy", 32'(bcd_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and add: clrld 0x05, addld 0x07, add, add.
    step(LOAD, CLR,  CLR,  ULA_ADD, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    exp_bcd_q.push_back(12'h000);
    exp_busy_q.push_back(8);
    step(LOAD, LOAD, HOLD, ULA_ADD, 8'h07, 8'h07, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'h07, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'h07, 8'h13, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_bcd();

    // Overflow: 0xFF + 0x01 wraps, ovf sticky, cleared by Ty = CLR.
    step(LOAD, CLR,  HOLD, ULA_ADD, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(LOAD, LOAD, HOLD, ULA_ADD, 8'h01, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    step(HOLD, CLR,  HOLD, ULA_ADD, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Subtract and shift, then a borrowing subtract and an X shift.
    step(LOAD, CLR,  HOLD, ULA_ADD, 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(LOAD, LOAD, HOLD, ULA_ADD, 8'h03, 8'h03, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    step(HOLD, LOAD, HOLD, ULA_SUB, 8'h00, 8'h03, 8'h0D, 8'h00, 1'b1, 1'b0, 1'b0);
    step(HOLD, SHR,  HOLD, ULA_ADD, 8'h00, 8'h03, 8'h06, 8'h00, 1'b0, 1'b0, 1'b0);
    step(LOAD, HOLD, HOLD, ULA_ADD, 8'h05, 8'h05, 8'h06, 8'h00, 1'b0, 1'b0, 1'b0);
    step(HOLD, LOAD, HOLD, ULA_SUB, 8'h00, 8'h05, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    step(HOLD, LOAD, HOLD, ULA_SUB, 8'h00, 8'h05, 8'hFC, 8'h00, 1'b0, 1'b1, 1'b0);
    step(SHR,  HOLD, HOLD, ULA_ADD, 8'h00, 8'h02, 8'hFC, 8'h00, 1'b0, 1'b1, 1'b0);
    step(HOLD, CLR,  HOLD, ULA_ADD, 8'h00, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Display conversion of 0xFF.
    step(LOAD, CLR,  HOLD, ULA_ADD, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    step(CLR,  CLR,  LOAD, ULA_ADD, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    exp_bcd_q.push_back(12'h255);
    exp_busy_q.push_back(8);
    wait_bcd();

    // Restart: disp 0x2A, then disp 0x07 three edges later.
    step(LOAD, CLR,  HOLD, ULA_ADD, 8'h2A, 8'h2A, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'h2A, 8'h2A, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(CLR,  CLR,  LOAD, ULA_ADD, 8'h00, 8'h00, 8'h00, 8'h2A, 1'b0, 1'b0, 1'b1);
    step(LOAD, HOLD, HOLD, ULA_ADD, 8'h07, 8'h07, 8'h00, 8'h2A, 1'b0, 1'b0, 1'b1);
    step(HOLD, LOAD, HOLD, ULA_ADD, 8'h00, 8'h07, 8'h07, 8'h2A, 1'b0, 1'b0, 1'b0);
    step(CLR,  CLR,  LOAD, ULA_ADD, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1);
    exp_bcd_q.push_back(12'h007);
    exp_busy_q.push_back(11);
    @(posedge clk);
    #2;
    check("restart_bcd_hold",  32'(bcd_out),   32'(12'h255));
    check("restart_valid_low", 32'(bcd_valid), 32'(0));
    wait_bcd();

    // Z shift right starts a new conversion: 0x07 >> 1 = 0x03.
    step(HOLD, HOLD, SHR,  ULA_ADD, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1);
    exp_bcd_q.push_back(12'h003);
    exp_busy_q.push_back(8);
    wait_bcd();

    idle();
    idle();
    check("reg_queue_drained",  32'(exp_q.size()),      32'(0));
    check("bcd_queue_drained",  32'(exp_bcd_q.size()),  32'(0));
    check("busy_queue_drained", 32'(exp_busy_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
